demux_1xn_lanes: RTL and testbench
==================================

// Module: demux_1xn_lanes
// PURPOSE
//  Parametrised 1-to-N byte-lane demultiplexer for the PHY RX path; single-clock successor to the 2-lane dual-edge demux.
//  Collects NUM_LANES consecutive input words into a frame and presents them in parallel, each with its own valid bit.
//  Adds a packed mode that skips invalid words, a partial-frame flush and a frame strobe.
//  Sits between the RX deserialiser/byte-stripper and the lane consumers.
// PARAMETERS
//  WIDTH      8  bits per word/lane
//  NUM_LANES  4  output lanes per frame, >=2
//  PACK_MODE  0  0 = positional: every cycle fills a slot; 1 = packed: only valid_in=1 words fill slots
// PORTS
//  clk        in   1                single clock, all logic on posedge
//  reset      in   1                synchronous, active-high
//  data_in    in   WIDTH            input word
//  valid_in   in   1                data_in qualifier
//  flush      in   1                emit a partial frame now
//  data_out   out  NUM_LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]; lane 0 is the first word received
//  valid_out  out  NUM_LANES        per-lane valid of the presented frame
//  frame_stb  out  1                1-cycle pulse when a new frame is loaded into data_out/valid_out
//  slot_idx   out  $clog2(NUM_LANES)  next slot to fill (debug/verification)
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset: data_out=0, valid_out=0, frame_stb=0, slot_idx=0, capture buffer and its valid bits cleared. Reset overrides all inputs, mid-frame included; the partial frame is discarded and never emitted.
//  - Capture when not in reset:
//    - PACK_MODE=0: each cycle buf[slot_idx]<=data_in and bvalid[slot_idx]<=valid_in, then slot_idx++.
//    - PACK_MODE=1: same, but only in cycles where valid_in=1; in other cycles slot_idx holds.
//  - Frame complete: a capture into slot NUM_LANES-1 wraps slot_idx to 0. On the next posedge:
//    - data_out and valid_out load the full frame, including the word just captured.
//    - frame_stb=1 for that one cycle.
//  - Latency: last word of a frame on cycle t -> data_out/valid_out/frame_stb update on cycle t+1.
//  - Hold: data_out and valid_out keep the last frame until the next frame load; frame_stb=0 otherwise.
//  - Back-to-back frames: capture continues into slot 0 in the cycle the previous frame completes; no bubble, no lost word.
//  - Flush when slot_idx>0 or a word is captured this cycle:
//    - The partial frame is emitted like a full one: filled slots keep their data and bvalid; unfilled lanes get data=0, valid=0.
//    - frame_stb pulses; slot_idx returns to 0.
//  - Flush with the same-cycle valid_in: the word is captured first and is included in the flushed frame.
//  - Flush coinciding with a natural frame completion: a single frame is emitted, not two.
//  - Flush with slot_idx=0 and nothing captured: no-op, no strobe.
//  - PACK_MODE=0 flush: a positional slot captured with valid_in=0 is "filled" with valid=0.
//  - Width rule: slot_idx counts modulo NUM_LANES; NUM_LANES need not be a power of two, so wrap by compare, not by overflow.
//  - No back-pressure: the consumer must sample data_out on frame_stb.
// STRUCTURE
//  - Package phy_rx_pkg:
//    - function lane_idx_w(n) = max(1,$clog2(n))
//    - localparams for default WIDTH/NUM_LANES
//    - PACK_POSITIONAL=0, PACK_PACKED=1
//  - Sub-module demux_lane_slot (one per lane, generate loop).
//    - Holds buf/bvalid for one lane.
//    - Inputs: load_en, clear, data, valid.
//  - Top level holds slot_idx, the frame-complete/flush logic and the output registers.
// TESTING
//  1 Reset: assert reset 2 cycles with valid_in=1 -> data_out=0, valid_out=0, frame_stb=0, slot_idx=0.
//  2 Positional, N=4: send 0x11,0x22,0x33,0x44 (all valid) on cycles 1-4.
//    -> cycle 5: data_out=0x44332211, valid_out=4'b1111, frame_stb=1; cycle 6: frame_stb=0, data held.
//  3 Positional: send 0xA1, invalid, 0xA3, 0xA4 -> valid_out=4'b1101, lane1 data = whatever data_in was during the invalid cycle.
//  4 Packed: send 0x01, 2 idle cycles, 0x02,0x03,0x04 -> one frame 0x04030201, valid_out=4'b1111; slot_idx holds during idle.
//  5 Flush: packed, send 0xB1,0xB2, then flush with valid_in=1 data 0xB3
//    -> data_out=0x00B3B2B1, valid_out=4'b0111, frame_stb=1, slot_idx=0; flush with slot_idx=0 and idle -> no strobe.
//  6 Reset mid-frame after 2 words, then 4 new words -> only the new frame emitted.
//    Also repeat tests 2 and 4 with NUM_LANES=3 and WIDTH=10: wrap at slot 2, back-to-back frames with no gap.

Source files
------------

// File: rtl/demux_1xn_lanes_pkg.sv
`default_nettype none
// ============================================================================
// Package   : phy_rx_pkg
// Purpose   : Shared constants and helpers for the PHY RX lane demultiplexer.
// Revision  : 1.0 - initial release
// ============================================================================
package phy_rx_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_NUM_LANES = 4;

    localparam int PACK_POSITIONAL   = 0;
    localparam int PACK_PACKED       = 1;

    // Index width for a lane counter; never collapses to zero bits.
    function automatic int lane_idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1xn_lanes_slot.sv
`default_nettype none
// ============================================================================
// Module    : demux_lane_slot
// Purpose   : Capture buffer (word plus valid bit) for one output lane.
// Revision  : 1.0 - initial release
// ============================================================================
module demux_lane_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             load_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic [WIDTH-1:0] buf_data,
    output logic             buf_valid
);

    // Clear wins over load: the word captured on an emitting edge bypasses the buffer.
    always_ff @(posedge clk) begin
        if (clear) begin
            buf_data  <= '0;
            buf_valid <= 1'b0;
        end else if (load_en) begin
            buf_data  <= data;
            buf_valid <= valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_1xn_lanes.sv
`default_nettype none
// ============================================================================
// Module    : demux_1xn_lanes
// Purpose   : 1-to-N lane demultiplexer with packed mode, flush and frame strobe.
// Revision  : 1.0 - initial release
// ============================================================================
module demux_1xn_lanes
    import phy_rx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NUM_LANES = DEFAULT_NUM_LANES,
    parameter int PACK_MODE = PACK_POSITIONAL
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [WIDTH-1:0]                    data_in,
    input  logic                                valid_in,
    input  logic                                flush,
    output logic [NUM_LANES*WIDTH-1:0]          data_out,
    output logic [NUM_LANES-1:0]                valid_out,
    output logic                                frame_stb,
    output logic [lane_idx_w(NUM_LANES)-1:0]    slot_idx
);

    localparam int                IDX_W     = lane_idx_w(NUM_LANES);
    localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(NUM_LANES - 1);

    logic                         w_capture;
    logic                         w_emit;
    logic [NUM_LANES-1:0]         w_load;
    logic [NUM_LANES-1:0]         w_buf_valid;
    logic [NUM_LANES*WIDTH-1:0]   w_buf_data;
    logic [NUM_LANES*WIDTH-1:0]   w_frame_data;
    logic [NUM_LANES-1:0]         w_frame_valid;

    assign w_capture = (PACK_MODE == PACK_PACKED) ? valid_in : 1'b1;

    // A completing capture and a flush in the same cycle produce one frame.
    assign w_emit = (w_capture && (slot_idx == LAST_SLOT))
                  || (flush && ((slot_idx != '0) || w_capture));

    generate
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
            assign w_load[k] = w_capture && (slot_idx == IDX_W'(k));

            demux_lane_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk       (clk),
                .load_en   (w_load[k]),
                .clear     (reset || w_emit),
                .data      (data_in),
                .valid     (valid_in),
                .buf_data  (w_buf_data[k*WIDTH +: WIDTH]),
                .buf_valid (w_buf_valid[k])
            );

            // Unfilled slots are always cleared, so they read back as data=0, valid=0.
            assign w_frame_data[k*WIDTH +: WIDTH] = w_load[k] ? data_in  : w_buf_data[k*WIDTH +: WIDTH];
            assign w_frame_valid[k]               = w_load[k] ? valid_in : w_buf_valid[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= '0;
            frame_stb <= 1'b0;
            slot_idx  <= '0;
        end else begin
            frame_stb <= w_emit;
            if (w_emit) begin
                data_out  <= w_frame_data;
                valid_out <= w_frame_valid;
                slot_idx  <= '0;
            end else if (w_capture) begin
                slot_idx  <= slot_idx + IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_1xn_lanes.sv
`default_nettype none
// ============================================================================
// Module    : tb_demux_1xn_lanes
// Purpose   : Self-checking bench: four configurations against a frame-queue model.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_demux_1xn_lanes;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in = 1'b0;
    logic       flush = 1'b0;
    logic [9:0] din = '0;

    always #5 clk = ~clk;

    // Configurations: 0 = N4/W8 positional, 1 = N4/W8 packed, 2 = N3/W10 positional, 3 = N3/W10 packed
    int NL[4]   = '{4, 4, 3, 3};
    int WD[4]   = '{8, 8, 10, 10};
    int PACK[4] = '{0, 1, 0, 1};

    logic [31:0] do_p4, do_k4;
    logic [29:0] do_p3, do_k3;
    logic [3:0]  vo_p4, vo_k4;
    logic [2:0]  vo_p3, vo_k3;
    logic        st_p4, st_k4, st_p3, st_k3;
    logic [1:0]  si_p4, si_k4, si_p3, si_k3;

    demux_1xn_lanes #(.WIDTH(8), .NUM_LANES(4), .PACK_MODE(0)) dut_p4 (
        .clk(clk), .reset(reset), .data_in(din[7:0]), .valid_in(valid_in), .flush(flush),
        .data_out(do_p4), .valid_out(vo_p4), .frame_stb(st_p4), .slot_idx(si_p4));
    demux_1xn_lanes #(.WIDTH(8), .NUM_LANES(4), .PACK_MODE(1)) dut_k4 (
        .clk(clk), .reset(reset), .data_in(din[7:0]), .valid_in(valid_in), .flush(flush),
        .data_out(do_k4), .valid_out(vo_k4), .frame_stb(st_k4), .slot_idx(si_k4));
    demux_1xn_lanes #(.WIDTH(10), .NUM_LANES(3), .PACK_MODE(0)) dut_p3 (
        .clk(clk), .reset(reset), .data_in(din), .valid_in(valid_in), .flush(flush),
        .data_out(do_p3), .valid_out(vo_p3), .frame_stb(st_p3), .slot_idx(si_p3));
    demux_1xn_lanes #(.WIDTH(10), .NUM_LANES(3), .PACK_MODE(1)) dut_k3 (
        .clk(clk), .reset(reset), .data_in(din), .valid_in(valid_in), .flush(flush),
        .data_out(do_k3), .valid_out(vo_k3), .frame_stb(st_k3), .slot_idx(si_k3));

    logic [39:0] act_data[4];
    logic [3:0]  act_valid[4];
    logic        act_stb[4];
    logic [1:0]  act_slot[4];

    assign act_data[0] = 40'(do_p4);  assign act_valid[0] = vo_p4;        assign act_stb[0] = st_p4;  assign act_slot[0] = si_p4;
    assign act_data[1] = 40'(do_k4);  assign act_valid[1] = vo_k4;        assign act_stb[1] = st_k4;  assign act_slot[1] = si_k4;
    assign act_data[2] = 40'(do_p3);  assign act_valid[2] = {1'b0, vo_p3}; assign act_stb[2] = st_p3; assign act_slot[2] = si_p3;
    assign act_data[3] = 40'(do_k3);  assign act_valid[3] = {1'b0, vo_k3}; assign act_stb[3] = st_k3; assign act_slot[3] = si_k3;

    // Reference model: a list of pending words per configuration, emitted when full or flushed.
    logic [10:0] pend[4][4];
    int          cnt[4];
    logic [39:0] exp_data[4];
    logic [3:0]  exp_valid[4];
    logic        exp_stb[4];
    logic [1:0]  exp_slot[4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic model_step();
        for (int d = 0; d < 4; d++) begin
            exp_stb[d] = 1'b0;
            if (reset) begin
                cnt[d]       = 0;
                exp_data[d]  = '0;
                exp_valid[d] = '0;
            end else begin
                if (PACK[d] == 0 || valid_in)
                    begin
                        pend[d][cnt[d]] = {valid_in, (WD[d] == 8) ? (din & 10'h0FF) : din};
                        cnt[d]++;
                    end
                if (cnt[d] == NL[d] || (flush && cnt[d] > 0)) begin
                    exp_data[d]  = '0;
                    exp_valid[d] = '0;
                    for (int k = 0; k < cnt[d]; k++) begin
                        exp_data[d]  = exp_data[d] | (40'(pend[d][k][9:0]) << (k * WD[d]));
                        exp_valid[d][k] = pend[d][k][10];
                    end
                    exp_stb[d] = 1'b1;
                    cnt[d]     = 0;
                end
            end
            exp_slot[d] = 2'(cnt[d]);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [9:0] dd, input logic f);
        reset = r; valid_in = v; din = dd; flush = f;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 10'h3FF, 1'b0);
        drive(1'b1, 1'b1, 10'h155, 1'b1);
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (act_data[d] !== 40'h0 || act_valid[d] !== 4'h0 || act_stb[d] !== 1'b0 || act_slot[d] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got data=%h valid=%b stb=%b slot=%0d, want all zero",
                         d, act_data[d], act_valid[d], act_stb[d], act_slot[d]);
            end
        end
    endtask

    task automatic test_positional();
        logic [9:0] seq[5] = '{10'h11, 10'h22, 10'h33, 10'h44, 10'h000};
        drive(1'b1, 1'b0, 10'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, i < 4, seq[i], 1'b0);
            for (int d = 0; d < 4; d++) begin
                n_tests++;
                if (act_data[d] !== exp_data[d] || act_valid[d] !== exp_valid[d] || act_stb[d] !== exp_stb[d] || act_slot[d] !== exp_slot[d]) begin
                    n_fail++;
                    $display("FAIL positional dut%0d cyc%0d: got data=%h valid=%b stb=%b slot=%0d, want data=%h valid=%b stb=%b slot=%0d",
                             d, cyc, act_data[d], act_valid[d], act_stb[d], act_slot[d], exp_data[d], exp_valid[d], exp_stb[d], exp_slot[d]);
                end
            end
            if (i == 3) begin
                n_tests++;
                if (act_data[0] !== 40'h44332211 || act_valid[0] !== 4'hF || act_stb[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL positional_frame: got data=%h valid=%b stb=%b, want 44332211 1111 1", act_data[0], act_valid[0], act_stb[0]);
                end
            end
        end
        n_tests++;
        if (act_stb[0] !== 1'b0 || act_data[0] !== 40'h44332211) begin
            n_fail++;
            $display("FAIL positional_hold: got data=%h stb=%b, want 44332211 0", act_data[0], act_stb[0]);
        end
    endtask

    task automatic test_invalid_slot();
        logic [9:0] seq[4] = '{10'hA1, 10'h5A, 10'hA3, 10'hA4};
        drive(1'b1, 1'b0, 10'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i != 1, seq[i], 1'b0);
            for (int d = 0; d < 4; d++) begin
                n_tests++;
                if (act_data[d] !== exp_data[d] || act_valid[d] !== exp_valid[d] || act_stb[d] !== exp_stb[d] || act_slot[d] !== exp_slot[d]) begin
                    n_fail++;
                    $display("FAIL invalid_slot dut%0d cyc%0d: got data=%h valid=%b stb=%b slot=%0d, want data=%h valid=%b stb=%b slot=%0d",
                             d, cyc, act_data[d], act_valid[d], act_stb[d], act_slot[d], exp_data[d], exp_valid[d], exp_stb[d], exp_slot[d]);
                end
            end
        end
        n_tests++;
        if (act_data[0] !== 40'hA4A35AA1 || act_valid[0] !== 4'b1101 || act_stb[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_slot_frame: got data=%h valid=%b stb=%b, want a4a35aa1 1101 1", act_data[0], act_valid[0], act_stb[0]);
        end
    endtask

    task automatic test_packed();
        logic [9:0] seq[6] = '{10'h01, 10'h3C, 10'h3D, 10'h02, 10'h03, 10'h04};
        drive(1'b1, 1'b0, 10'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, i != 1 && i != 2, seq[i], 1'b0);
            for (int d = 0; d < 4; d++) begin
                n_tests++;
                if (act_data[d] !== exp_data[d] || act_valid[d] !== exp_valid[d] || act_stb[d] !== exp_stb[d] || act_slot[d] !== exp_slot[d]) begin
                    n_fail++;
                    $display("FAIL packed dut%0d cyc%0d: got data=%h valid=%b stb=%b slot=%0d, want data=%h valid=%b stb=%b slot=%0d",
                             d, cyc, act_data[d], act_valid[d], act_stb[d], act_slot[d], exp_data[d], exp_valid[d], exp_stb[d], exp_slot[d]);
                end
            end
            if (i == 2) begin
                n_tests++;
                if (act_slot[1] !== 2'd1 || act_stb[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL packed_idle_hold: got slot=%0d stb=%b, want 1 0", act_slot[1], act_stb[1]);
                end
            end
        end
        n_tests++;
        if (act_data[1] !== 40'h04030201 || act_valid[1] !== 4'hF || act_stb[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL packed_frame: got data=%h valid=%b stb=%b, want 04030201 1111 1", act_data[1], act_valid[1], act_stb[1]);
        end
    endtask

    task automatic test_flush();
        logic [9:0] seq[5] = '{10'hB1, 10'hB2, 10'hB3, 10'h0, 10'h0};
        logic       fl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       vl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        drive(1'b1, 1'b0, 10'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, vl[i], seq[i], fl[i]);
            for (int d = 0; d < 4; d++) begin
                n_tests++;
                if (act_data[d] !== exp_data[d] || act_valid[d] !== exp_valid[d] || act_stb[d] !== exp_stb[d] || act_slot[d] !== exp_slot[d]) begin
                    n_fail++;
                    $display("FAIL flush dut%0d cyc%0d: got data=%h valid=%b stb=%b slot=%0d, want data=%h valid=%b stb=%b slot=%0d",
                             d, cyc, act_data[d], act_valid[d], act_stb[d], act_slot[d], exp_data[d], exp_valid[d], exp_stb[d], exp_slot[d]);
                end
            end
            if (i == 2) begin
                n_tests++;
                if (act_data[1] !== 40'h00B3B2B1 || act_valid[1] !== 4'b0111 || act_stb[1] !== 1'b1 || act_slot[1] !== 2'd0) begin
                    n_fail++;
                    $display("FAIL flush_partial: got data=%h valid=%b stb=%b slot=%0d, want 00b3b2b1 0111 1 0",
                             act_data[1], act_valid[1], act_stb[1], act_slot[1]);
                end
            end
        end
        n_tests++;
        if (act_stb[1] !== 1'b0 || act_data[1] !== 40'h00B3B2B1) begin
            n_fail++;
            $display("FAIL flush_empty_noop: got stb=%b data=%h, want 0 00b3b2b1", act_stb[1], act_data[1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] seq[6] = '{10'h0E1, 10'h0E2, 10'h0C1, 10'h0C2, 10'h0C3, 10'h0C4};
        drive(1'b1, 1'b0, 10'h0, 1'b0);
        drive(1'b0, 1'b1, seq[0], 1'b0);
        drive(1'b0, 1'b1, seq[1], 1'b0);
        drive(1'b1, 1'b1, 10'h0FF, 1'b0);
        for (int i = 2; i < 6; i++) begin
            drive(1'b0, 1'b1, seq[i], 1'b0);
            for (int d = 0; d < 4; d++) begin
                n_tests++;
                if (act_data[d] !== exp_data[d] || act_valid[d] !== exp_valid[d] || act_stb[d] !== exp_stb[d] || act_slot[d] !== exp_slot[d]) begin
                    n_fail++;
                    $display("FAIL reset_mid dut%0d cyc%0d: got data=%h valid=%b stb=%b slot=%0d, want data=%h valid=%b stb=%b slot=%0d",
                             d, cyc, act_data[d], act_valid[d], act_stb[d], act_slot[d], exp_data[d], exp_valid[d], exp_stb[d], exp_slot[d]);
                end
            end
        end
        n_tests++;
        if (act_data[0] !== 40'hC4C3C2C1 || act_valid[0] !== 4'hF || act_stb[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got data=%h valid=%b stb=%b, want c4c3c2c1 1111 1", act_data[0], act_valid[0], act_stb[0]);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 10'h0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b1, 10'($urandom), 1'b0);
            for (int d = 0; d < 4; d++) begin
                n_tests++;
                if (act_data[d] !== exp_data[d] || act_valid[d] !== exp_valid[d] || act_stb[d] !== exp_stb[d] || act_slot[d] !== exp_slot[d]) begin
                    n_fail++;
                    $display("FAIL back_to_back dut%0d cyc%0d: got data=%h valid=%b stb=%b slot=%0d, want data=%h valid=%b stb=%b slot=%0d",
                             d, cyc, act_data[d], act_valid[d], act_stb[d], act_slot[d], exp_data[d], exp_valid[d], exp_stb[d], exp_slot[d]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 10'($urandom), $urandom_range(0, 7) == 0);
            for (int d = 0; d < 4; d++) begin
                n_tests++;
                if (act_data[d] !== exp_data[d] || act_valid[d] !== exp_valid[d] || act_stb[d] !== exp_stb[d] || act_slot[d] !== exp_slot[d]) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: got data=%h valid=%b stb=%b slot=%0d, want data=%h valid=%b stb=%b slot=%0d",
                             d, cyc, act_data[d], act_valid[d], act_stb[d], act_slot[d], exp_data[d], exp_valid[d], exp_stb[d], exp_slot[d]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            cnt[d] = 0; exp_data[d] = '0; exp_valid[d] = '0; exp_stb[d] = 1'b0; exp_slot[d] = '0;
        end
        test_reset();
        test_positional();
        test_invalid_slot();
        test_packed();
        test_flush();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
